// File: rtl/cache_arbiter.sv
// Arbitrates the single pmem port between I-cache and D-cache line misses, one transfer in flight.
// Define ARB_FAIR_EN for round-robin between simultaneous requesters; default is fixed D-over-I priority.
module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int OFFS = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFFS) - ADDR_W'(1));

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RESP} state_t;

    state_t            state, next_state;
    logic              d_req;
    logic              grant_d, grant_i;
    logic              op_write;
    logic              served_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    assign d_req = d_read | d_write;

`ifdef ARB_FAIR_EN
    logic last_grant_d;

    // On contention the side that did not win last time goes first.
    always_comb begin
        grant_d = d_req;
        if (d_req && i_read) begin
            grant_d = !last_grant_d;
        end
        grant_i = i_read && !grant_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_d <= 1'b0;
        end else if (state == IDLE && (grant_d || grant_i)) begin
            last_grant_d <= grant_d;
        end
    end
`else
    always_comb begin
        grant_d = d_req;
        grant_i = i_read && !d_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    next_state = SERVE_D;
                end else if (grant_i) begin
                    next_state = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    next_state = RESP;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Request fields are captured once at grant so requester changes mid-transfer are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            op_write <= 1'b0;
            served_d <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            if (state == IDLE) begin
                if (grant_d) begin
                    addr_q   <= d_address & ALIGN_MASK;
                    wdata_q  <= d_wdata;
                    op_write <= d_write;
                    served_d <= 1'b1;
                end else if (grant_i) begin
                    addr_q   <= i_address & ALIGN_MASK;
                    op_write <= 1'b0;
                    served_d <= 1'b0;
                end
            end
            if (pmem_resp && !op_write) begin
                if (state == SERVE_D) begin
                    d_rdata <= pmem_rdata;
                end else if (state == SERVE_I) begin
                    i_rdata <= pmem_rdata;
                end
            end
        end
    end

    always_comb begin
        pmem_read    = (state == SERVE_I || state == SERVE_D) && !op_write;
        pmem_write   = (state == SERVE_I || state == SERVE_D) && op_write;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        i_resp       = (state == RESP) && !served_d;
        d_resp       = (state == RESP) && served_d;
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: transaction-level reference model checked every cycle plus directed scenarios.
// Honours ARB_FAIR_EN so the same bench covers both arbitration policies.
module tb_cache_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;
    localparam int BYTES  = LINE_W / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    int checks = 0;
    int errors = 0;

    cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [LINE_W-1:0] act,
                                input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: who owns pmem (0 none, 1 I, 2 D) and who is owed a response this cycle.
    int                m_owner = 0;
    int                m_resp_to = 0;
    int                m_last = 1;
    bit                m_write = 1'b0;
    bit                model_valid = 1'b0;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata, m_irdata, m_drdata;

    always @(posedge clk) begin
        int pick;
        if (reset) begin
            m_owner = 0; m_resp_to = 0; m_last = 1; m_write = 1'b0;
            m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
            model_valid = 1'b1;
        end else if (m_resp_to != 0) begin
            m_resp_to = 0;
        end else if (m_owner != 0) begin
            if (pmem_resp) begin
                if (!m_write) begin
                    if (m_owner == 2) m_drdata = pmem_rdata;
                    else m_irdata = pmem_rdata;
                end
                m_resp_to = m_owner;
                m_owner = 0;
            end
        end else begin
            pick = 0;
            if ((d_read || d_write) && i_read) begin
`ifdef ARB_FAIR_EN
                pick = (m_last == 2) ? 1 : 2;
`else
                pick = 2;
`endif
            end else if (d_read || d_write) begin
                pick = 2;
            end else if (i_read) begin
                pick = 1;
            end
            if (pick == 2) begin
                m_addr  = (d_address / BYTES) * BYTES;
                m_write = d_write;
                m_wdata = d_wdata;
            end else if (pick == 1) begin
                m_addr  = (i_address / BYTES) * BYTES;
                m_write = 1'b0;
            end
            if (pick != 0) begin
                m_owner = pick;
                m_last  = pick;
            end
        end
        #1;
        if (model_valid) begin
            check_output("pmem_read", pmem_read, (m_owner != 0) && !m_write);
            check_output("pmem_write", pmem_write, (m_owner != 0) && m_write);
            check_output("i_resp", i_resp, m_resp_to == 1);
            check_output("d_resp", d_resp, m_resp_to == 2);
            check_output("i_rdata", i_rdata, m_irdata);
            check_output("d_rdata", d_rdata, m_drdata);
            if (m_owner != 0) check_output("pmem_address", pmem_address, m_addr);
            if (m_owner != 0 && m_write) check_output("pmem_wdata", pmem_wdata, m_wdata);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic ir, input logic [ADDR_W-1:0] ia, input logic dr,
                                  input logic dw, input logic [ADDR_W-1:0] da,
                                  input logic [LINE_W-1:0] dwd);
        i_read = ir; i_address = ia; d_read = dr; d_write = dw; d_address = da; d_wdata = dwd;
    endtask

    // Memory side: wait for a strobe, hold for lat cycles, then pulse pmem_resp for one cycle.
    task automatic serve_mem(input int lat, input logic [LINE_W-1:0] data);
        int n = 0;
        while (!(pmem_read || pmem_write) && n < 20) begin
            tick();
            n++;
        end
        check_output("strobe_seen", n < 20, 1'b1);
        if (n >= 20) return;
        repeat (lat) tick();
        pmem_rdata = data;
        pmem_resp  = 1'b1;
        tick();
        pmem_resp  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [LINE_W-1:0] data_a5, data_dead, data1, data2;
        int grants[4];
        int exp_grants[4];
        bit first_is_d;

        data_a5   = {32{8'hA5}};
        data_dead = {8{32'hDEADBEEF}};
        data1     = {8{32'h1111_0001}};
        data2     = {8{32'h2222_0002}};
        reset = 1'b1;
        pmem_rdata = '0;
        pmem_resp = 1'b0;
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        do_reset();
        check_output("reset_strobes", {pmem_read, pmem_write, i_resp, d_resp}, 4'b0);
        check_output("reset_address", pmem_address, 32'h0);
        check_output("reset_rdata", i_rdata | d_rdata | pmem_wdata, '0);

        $display("[TB] I-cache read with 3-cycle memory latency");
        apply_stimulus(1'b1, 32'h0000_1234, 1'b0, 1'b0, '0, '0);
        tick();
        check_output("t1_read", pmem_read, 1'b1);
        check_output("t1_address", pmem_address, 32'h0000_1220);
        serve_mem(3, data_a5);
        check_output("t1_iresp", i_resp, 1'b1);
        check_output("t1_read_in_resp", pmem_read, 1'b0);
        check_output("t1_irdata", i_rdata, data_a5);
        i_read = 1'b0;
        tick();
        check_output("t1_iresp_pulse", i_resp, 1'b0);

        $display("[TB] D-cache writeback");
        apply_stimulus(1'b0, '0, 1'b0, 1'b1, 32'h8000_0040, data_dead);
        tick();
        check_output("t2_write", {pmem_write, pmem_read}, 2'b10);
        check_output("t2_address", pmem_address, 32'h8000_0040);
        check_output("t2_wdata", pmem_wdata, data_dead);
        serve_mem(2, data1);
        check_output("t2_dresp", d_resp, 1'b1);
        check_output("t2_drdata", d_rdata, '0);
        d_write = 1'b0;
        tick();

        $display("[TB] simultaneous I and D reads");
`ifdef ARB_FAIR_EN
        first_is_d = 1'b0;
`else
        first_is_d = 1'b1;
`endif
        apply_stimulus(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_2000, '0);
        tick();
        check_output("t3_first_addr", pmem_address, first_is_d ? 32'h0000_2000 : 32'h0000_0100);
        serve_mem(1, data1);
        check_output("t3_first_resp", {d_resp, i_resp}, first_is_d ? 2'b10 : 2'b01);
        if (first_is_d) d_read = 1'b0;
        else i_read = 1'b0;
        serve_mem(0, data2);
        check_output("t3_second_resp", {d_resp, i_resp}, first_is_d ? 2'b01 : 2'b10);
        check_output("t3_drdata", d_rdata, first_is_d ? data1 : data2);
        check_output("t3_irdata", i_rdata, first_is_d ? data2 : data1);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        tick();

        $display("[TB] both sides requesting for four transfers");
        do_reset();
        apply_stimulus(1'b1, 32'h0000_0400, 1'b1, 1'b0, 32'h0000_0800, '0);
        for (int k = 0; k < 4; k++) begin
            serve_mem(1, {8{32'(k + 32'h50)}});
            grants[k] = d_resp ? 2 : (i_resp ? 1 : 0);
        end
`ifdef ARB_FAIR_EN
        exp_grants = '{2, 1, 2, 1};
`else
        exp_grants = '{2, 2, 2, 2};
`endif
        for (int k = 0; k < 4; k++) check_output("t4_grant", grants[k], exp_grants[k]);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        tick();

        $display("[TB] reset during SERVE_D");
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 32'h0000_0040, '0);
        tick();
        check_output("t5_read", pmem_read, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        d_read = 1'b0;
        check_output("t5_after_reset", {pmem_read, pmem_write, i_resp, d_resp}, 4'b0);
        pmem_rdata = data2;
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        tick();
        check_output("t5_late_resp", {pmem_read, pmem_write, i_resp, d_resp}, 4'b0);
        check_output("t5_drdata", d_rdata, '0);

        $display("[TB] address change during SERVE_I");
        apply_stimulus(1'b1, 32'h0000_3000, 1'b0, 1'b0, '0, '0);
        tick();
        check_output("t6_addr0", pmem_address, 32'h0000_3000);
        i_address = 32'hFFFF_FFFF;
        tick();
        check_output("t6_addr1", pmem_address, 32'h0000_3000);
        serve_mem(1, data_dead);
        check_output("t6_iresp", i_resp, 1'b1);
        check_output("t6_irdata", i_rdata, data_dead);
        i_read = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
